// File: rtl/vga_timing_gen_if.sv
// Raster timing bundle from vga_timing_gen to the drawing stages and VGA connector.
// frame_count exists only when VGA_FRAME_COUNT_EN is defined.
interface vga_timing_gen_if;
   logic [9:0]  DrawX;
   logic [9:0]  DrawY;
   logic        blank;
   logic        hs;
   logic        vs;
   logic        frame_end;
`ifdef VGA_FRAME_COUNT_EN
   logic [15:0] frame_count;

   modport master (output DrawX, DrawY, blank, hs, vs, frame_end, frame_count);
   modport slave  (input  DrawX, DrawY, blank, hs, vs, frame_end, frame_count);
`else
   modport master (output DrawX, DrawY, blank, hs, vs, frame_end);
   modport slave  (input  DrawX, DrawY, blank, hs, vs, frame_end);
`endif
endinterface

// File: rtl/vga_timing_gen.sv
// 640x480@60 raster timing generator: pixel counters, blank, delayed hs/vs, frame_end.
// Optional VGA_FRAME_COUNT_EN adds a 16-bit wrapping frame counter.
module vga_timing_gen #(
   parameter int unsigned H_VISIBLE  = 640,
   parameter int unsigned H_FRONT    = 16,
   parameter int unsigned H_SYNC     = 96,
   parameter int unsigned H_BACK     = 48,
   parameter int unsigned V_VISIBLE  = 480,
   parameter int unsigned V_FRONT    = 10,
   parameter int unsigned V_SYNC     = 2,
   parameter int unsigned V_BACK     = 33,
   parameter int unsigned SYNC_DELAY = 1
) (
   input  logic             vga_clk,
   input  logic             reset_n,
   vga_timing_gen_if.master vga
);

   localparam int unsigned CW       = 10;
   localparam int unsigned H_TOTAL  = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
   localparam int unsigned V_TOTAL  = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
   localparam int unsigned HS_START = H_VISIBLE + H_FRONT;
   localparam int unsigned HS_END   = HS_START + H_SYNC - 1;
   localparam int unsigned VS_START = V_VISIBLE + V_FRONT;
   localparam int unsigned VS_END   = VS_START + V_SYNC - 1;

   logic [CW-1:0] hc;
   logic [CW-1:0] vc;
   logic          h_last;
   logic          v_last;
   logic          hs_raw;
   logic          vs_raw;
   logic          blank_c;

   assign h_last = (hc == CW'(H_TOTAL - 1));
   assign v_last = (vc == CW'(V_TOTAL - 1));

   // Raster counters: hc every clock, vc on line wrap, both wrap together at frame end
   always_ff @(posedge vga_clk or negedge reset_n) begin
      if (!reset_n) begin
         hc <= '0;
         vc <= '0;
      end else if (h_last) begin
         hc <= '0;
         vc <= v_last ? '0 : vc + CW'(1);
      end else begin
         hc <= hc + CW'(1);
      end
   end

   // Undelayed decodes straight from the counter registers
   always_comb begin
      blank_c = 1'b0;
      hs_raw  = 1'b1;
      vs_raw  = 1'b1;
      blank_c = (hc < CW'(H_VISIBLE)) && (vc < CW'(V_VISIBLE));
      if ((hc >= CW'(HS_START)) && (hc <= CW'(HS_END))) hs_raw = 1'b0;
      if ((vc >= CW'(VS_START)) && (vc <= CW'(VS_END))) vs_raw = 1'b0;
   end

   assign vga.DrawX     = hc;
   assign vga.DrawY     = vc;
   assign vga.blank     = blank_c;
   assign vga.frame_end = h_last && v_last;

   // Sync pipeline keeps hs/vs aligned with registered RGB downstream
   generate
      if (SYNC_DELAY == 0) begin : g_no_dly
         assign vga.hs = hs_raw;
         assign vga.vs = vs_raw;
      end else begin : g_dly
         logic [SYNC_DELAY-1:0] hs_pipe;
         logic [SYNC_DELAY-1:0] vs_pipe;

         always_ff @(posedge vga_clk or negedge reset_n) begin
            if (!reset_n) begin
               hs_pipe <= '1;
               vs_pipe <= '1;
            end else begin
               hs_pipe[0] <= hs_raw;
               vs_pipe[0] <= vs_raw;
               for (int i = 1; i < int'(SYNC_DELAY); i++) begin
                  hs_pipe[i] <= hs_pipe[i-1];
                  vs_pipe[i] <= vs_pipe[i-1];
               end
            end
         end

         assign vga.hs = hs_pipe[SYNC_DELAY-1];
         assign vga.vs = vs_pipe[SYNC_DELAY-1];
      end
   endgenerate

`ifdef VGA_FRAME_COUNT_EN
   logic [15:0] frame_cnt;

   // Advances on the same edge that wraps the counters to (0,0)
   always_ff @(posedge vga_clk or negedge reset_n) begin
      if (!reset_n)
         frame_cnt <= '0;
      else if (h_last && v_last)
         frame_cnt <= frame_cnt + 16'(1);
   end

   assign vga.frame_count = frame_cnt;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: default geometry at three sync delays plus a
// reduced geometry instance for frame-level and reset corner cases.
module tb_vga_timing_gen;

   logic vga_clk;
   logic reset_n;

   int tests;
   int failed;

   vga_timing_gen_if if_d0 ();
   vga_timing_gen_if if_d1 ();
   vga_timing_gen_if if_d3 ();
   vga_timing_gen_if if_sm ();

   vga_timing_gen #(.SYNC_DELAY(0)) u_d0 (.vga_clk(vga_clk), .reset_n(reset_n), .vga(if_d0));
   vga_timing_gen #(.SYNC_DELAY(1)) u_d1 (.vga_clk(vga_clk), .reset_n(reset_n), .vga(if_d1));
   vga_timing_gen #(.SYNC_DELAY(3)) u_d3 (.vga_clk(vga_clk), .reset_n(reset_n), .vga(if_d3));

   // Small raster: H_TOTAL=15 (hs raw low hc 10..12), V_TOTAL=8 (vs raw low vc 5..6), 120 clk/frame
   vga_timing_gen #(
      .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
      .V_VISIBLE(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
      .SYNC_DELAY(1)
   ) u_sm (.vga_clk(vga_clk), .reset_n(reset_n), .vga(if_sm));

   initial vga_clk = 1'b0;
   always #5 vga_clk = ~vga_clk;

   typedef struct {
      int unsigned adv;
      int unsigned x;
      int unsigned y;
      bit          blank;
      bit          hs0;
      bit          hs1;
      bit          hs3;
      bit          vs;
      bit          fe;
   } vec_t;

   localparam int NVEC = 14;
   vec_t vecs [NVEC];

   task automatic chk(input string name, input int unsigned act, input int unsigned exp);
      tests++;
      if (act !== exp) begin
         failed++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic step(input int unsigned n);
      repeat (n) @(negedge vga_clk);
   endtask

   task automatic chk_sm_reset(input string tag);
      chk({tag, " sm DrawX"}, int'(if_sm.DrawX), 0);
      chk({tag, " sm DrawY"}, int'(if_sm.DrawY), 0);
      chk({tag, " sm blank"}, int'(if_sm.blank), 1);
      chk({tag, " sm hs"}, int'(if_sm.hs), 1);
      chk({tag, " sm vs"}, int'(if_sm.vs), 1);
      chk({tag, " sm frame_end"}, int'(if_sm.frame_end), 0);
   endtask

   initial begin
      int unsigned fall0, fall1, fall3, low0, low1, low3;
      logic        p0, p1, p3;
      int unsigned fe_cnt, fe_x, fe_y, vs_low_f0, vs_low_f1;

      tests   = 0;
      failed  = 0;
      reset_n = 1'b0;

      //            adv   x    y  blk hs0 hs1 hs3 vs fe
      vecs[0]  = '{0,    0,   0, 1,  1,  1,  1,  1, 0};
      vecs[1]  = '{1,    1,   0, 1,  1,  1,  1,  1, 0};
      vecs[2]  = '{638,  639, 0, 1,  1,  1,  1,  1, 0};
      vecs[3]  = '{1,    640, 0, 0,  1,  1,  1,  1, 0};
      vecs[4]  = '{16,   656, 0, 0,  0,  1,  1,  1, 0};
      vecs[5]  = '{1,    657, 0, 0,  0,  0,  1,  1, 0};
      vecs[6]  = '{2,    659, 0, 0,  0,  0,  0,  1, 0};
      vecs[7]  = '{93,   752, 0, 0,  1,  0,  0,  1, 0};
      vecs[8]  = '{1,    753, 0, 0,  1,  1,  0,  1, 0};
      vecs[9]  = '{1,    754, 0, 0,  1,  1,  0,  1, 0};
      vecs[10] = '{1,    755, 0, 0,  1,  1,  1,  1, 0};
      vecs[11] = '{44,   799, 0, 0,  1,  1,  1,  1, 0};
      vecs[12] = '{1,    0,   1, 1,  1,  1,  1,  1, 0};
      vecs[13] = '{639,  639, 1, 1,  1,  1,  1,  1, 0};

      step(3);
      reset_n = 1'b1;

      // Default geometry: walk across line 0 into line 1
      for (int i = 0; i < NVEC; i++) begin
         step(vecs[i].adv);
         chk($sformatf("v%0d DrawX", i), int'(if_d1.DrawX), vecs[i].x);
         chk($sformatf("v%0d DrawY", i), int'(if_d1.DrawY), vecs[i].y);
         chk($sformatf("v%0d blank", i), int'(if_d1.blank), int'(vecs[i].blank));
         chk($sformatf("v%0d hs d0", i), int'(if_d0.hs), int'(vecs[i].hs0));
         chk($sformatf("v%0d hs d1", i), int'(if_d1.hs), int'(vecs[i].hs1));
         chk($sformatf("v%0d hs d3", i), int'(if_d3.hs), int'(vecs[i].hs3));
         chk($sformatf("v%0d vs", i), int'(if_d1.vs), int'(vecs[i].vs));
         chk($sformatf("v%0d frame_end", i), int'(if_d1.frame_end), int'(vecs[i].fe));
      end
      chk("d3 DrawX tracks d1", int'(if_d3.DrawX), 639);

      // hs falling position and low width over one full line, per sync delay
      fall0 = 999; fall1 = 999; fall3 = 999;
      low0 = 0; low1 = 0; low3 = 0;
      p0 = if_d0.hs; p1 = if_d1.hs; p3 = if_d3.hs;
      for (int k = 0; k < 800; k++) begin
         step(1);
         if (!if_d0.hs) low0++;
         if (!if_d1.hs) low1++;
         if (!if_d3.hs) low3++;
         if (p0 && !if_d0.hs) fall0 = int'(if_d0.DrawX);
         if (p1 && !if_d1.hs) fall1 = int'(if_d1.DrawX);
         if (p3 && !if_d3.hs) fall3 = int'(if_d3.DrawX);
         p0 = if_d0.hs; p1 = if_d1.hs; p3 = if_d3.hs;
      end
      chk("hs fall hc d0", fall0, 656);
      chk("hs fall hc d1", fall1, 657);
      chk("hs fall hc d3", fall3, 659);
      chk("hs width d0", low0, 96);
      chk("hs width d1", low1, 96);
      chk("hs width d3", low3, 96);

      // Fresh start for the small-raster frame checks
      reset_n = 1'b0;
      step(2);
      chk_sm_reset("pre-frame");
      reset_n = 1'b1;

      fe_cnt = 0; fe_x = 999; fe_y = 999; vs_low_f0 = 0; vs_low_f1 = 0;
      for (int k = 1; k <= 240; k++) begin
         step(1);
         if (if_sm.frame_end) begin
            fe_cnt++;
            fe_x = int'(if_sm.DrawX);
            fe_y = int'(if_sm.DrawY);
         end
         if (!if_sm.vs) begin
            if (k <= 120) vs_low_f0++;
            else          vs_low_f1++;
         end
      end
      chk("frame_end pulses", fe_cnt, 2);
      chk("frame_end x", fe_x, 14);
      chk("frame_end y", fe_y, 7);
      chk("vs width frame0", vs_low_f0, 30);
      chk("vs width frame1", vs_low_f1, 30);
      chk("wrap DrawX", int'(if_sm.DrawX), 0);
      chk("wrap DrawY", int'(if_sm.DrawY), 0);
      chk("wrap frame_end", int'(if_sm.frame_end), 0);

`ifdef VGA_FRAME_COUNT_EN
      chk("frame_count after 2", int'(if_sm.frame_count), 2);
      step(120);
      chk("frame_count after 3", int'(if_sm.frame_count), 3);
      step(30);
      force u_sm.frame_cnt = 16'hFFFF;
      step(1);
      release u_sm.frame_cnt;
      chk("frame_count loaded", int'(if_sm.frame_count), 65535);
      step(89);
      chk("frame_count wrap", int'(if_sm.frame_count), 0);
      chk("wrap after load DrawX", int'(if_sm.DrawX), 0);
`endif

      // Mid-frame asynchronous reset inside both sync pulses at (11,5)
      step(86);
      chk("pre-reset DrawX", int'(if_sm.DrawX), 11);
      chk("pre-reset DrawY", int'(if_sm.DrawY), 5);
      chk("pre-reset blank", int'(if_sm.blank), 0);
      chk("pre-reset hs", int'(if_sm.hs), 0);
      chk("pre-reset vs", int'(if_sm.vs), 0);
      #2;
      reset_n = 1'b0;
      #1;
      chk_sm_reset("async");
      chk("async d3 DrawX", int'(if_d3.DrawX), 0);
      chk("async d3 hs", int'(if_d3.hs), 1);
`ifdef VGA_FRAME_COUNT_EN
      chk("async frame_count", int'(if_sm.frame_count), 0);
`endif
      step(1);
      reset_n = 1'b1;
      step(1);
      chk("resume DrawX", int'(if_sm.DrawX), 1);
      chk("resume DrawY", int'(if_sm.DrawY), 0);
      step(14);
      chk("resume wrap DrawX", int'(if_sm.DrawX), 0);
      chk("resume wrap DrawY", int'(if_sm.DrawY), 1);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
